stream_broadcaster_n: RTL and testbench

N-way stream broadcaster with valid/ready handshakes. It replaces the fixed two-output broadcaster with a generalised block. One input transaction is delivered to a per-transaction subset of N output channels, selected by a destination mask. Each channel has an independent one-entry holding register, so slow consumers drain independently. The block sits between a producer stage and up to N parallel consumer stages in the stream pipeline.

---
 rtl/stream_broadcaster_n.sv | 52 +++++
 tb/tb_stream_broadcaster_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_broadcaster_n.sv
// stream_broadcaster_n: delivers one input transaction to a masked subset of N output channels,
// each channel owning a one-entry holding slot so consumers drain independently.
module stream_broadcaster_n #(
    parameter  int    N     = 2,
    parameter  int    WIDTH = 4,
    parameter  string SPLIT = "yes",
    parameter  string BURST = "yes",
    localparam int    IW    = (SPLIT == "yes") ? N * WIDTH : WIDTH
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iValid_AM,
    output logic               oReady_AM,
    input  logic [IW-1:0]      iData_AM,
    input  logic [N-1:0]       iMask_AM,
    output logic [N-1:0]       oValid_BM,
    input  logic [N-1:0]       iReady_BM,
    output logic [N*WIDTH-1:0] oData_BM
);
    logic [N-1:0]       valid_q, valid_d, load;
    logic [N*WIDTH-1:0] data_q, data_d, fan;
    logic               accept;
    generate
        if (SPLIT == "yes") begin : g_split
            assign fan = iData_AM;
        end else begin : g_copy
            assign fan = {N{iData_AM}};
        end
    endgenerate
    // Readiness ignores the mask so a transaction never overtakes an older one on any channel.
    always_comb begin
        oReady_AM = iRST & ((BURST == "yes") ? &(~valid_q | iReady_BM) : &(~valid_q));
        accept    = iValid_AM & oReady_AM;
        load      = iMask_AM & {N{accept}};
        valid_d   = (valid_q & ~iReady_BM) | load;
        data_d    = data_q;
        for (int k = 0; k < N; k++) begin
            data_d[k*WIDTH +: WIDTH] = load[k] ? fan[k*WIDTH +: WIDTH] : data_q[k*WIDTH +: WIDTH];
        end
    end
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign oValid_BM = valid_q;
    assign oData_BM  = data_q;
endmodule

// File: tb/tb_stream_broadcaster_n.sv
// tb_stream_broadcaster_n: scoreboard bench for a split/burst instance (a) and a copy/non-burst instance (b).
module tb_stream_broadcaster_n;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        va = 0, vb = 0, ora, orb;
    logic [11:0] da = 0, oda, odb;
    logic [3:0]  db = 0;
    logic [2:0]  ma = 0, mb = 0, ra = 0, rb = 0, ova, ovb;
    logic [3:0]  qa[3][$];
    logic [3:0]  qb[3][$];
    logic [3:0]  exp_d;
    int          n_pass = 0, n_total = 0, cyc = 0;

    stream_broadcaster_n #(.N(3), .WIDTH(4), .SPLIT("yes"), .BURST("yes")) dut_a (
        .iCLK(clk), .iRST(rst_n), .iValid_AM(va), .oReady_AM(ora), .iData_AM(da),
        .iMask_AM(ma), .oValid_BM(ova), .iReady_BM(ra), .oData_BM(oda));
    stream_broadcaster_n #(.N(3), .WIDTH(4), .SPLIT("no"), .BURST("no")) dut_b (
        .iCLK(clk), .iRST(rst_n), .iValid_AM(vb), .oReady_AM(orb), .iData_AM(db),
        .iMask_AM(mb), .oValid_BM(ovb), .iReady_BM(rb), .oData_BM(odb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Scoreboard: push on input accept, pop and compare on each output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (va && ora && ma[k]) qa[k].push_back(da[k*4 +: 4]);
                if (vb && orb && mb[k]) qb[k].push_back(db);
            end
            for (int k = 0; k < 3; k++) begin
                if (ova[k] && ra[k]) begin
                    n_total++;
                    if (qa[k].size() == 0) $display("FAIL sb_a_extra ch%0d: got handshake data %h required no handshake", k, oda[k*4 +: 4]);
                    else begin
                        exp_d = qa[k].pop_front();
                        if (oda[k*4 +: 4] !== exp_d) $display("FAIL sb_a ch%0d: got %h required %h", k, oda[k*4 +: 4], exp_d);
                        else n_pass++;
                    end
                end
                if (ovb[k] && rb[k]) begin
                    n_total++;
                    if (qb[k].size() == 0) $display("FAIL sb_b_extra ch%0d: got handshake data %h required no handshake", k, odb[k*4 +: 4]);
                    else begin
                        exp_d = qb[k].pop_front();
                        if (odb[k*4 +: 4] !== exp_d) $display("FAIL sb_b ch%0d: got %h required %h", k, odb[k*4 +: 4], exp_d);
                        else n_pass++;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_total++; if (ova !== 3'b000) $display("FAIL rst_valid: got %b required 000", ova); else n_pass++;
        n_total++; if (ora !== 1'b0) $display("FAIL rst_ready: got %b required 0", ora); else n_pass++;
        n_total++; if (oda !== 12'h000) $display("FAIL rst_data: got %h required 000", oda); else n_pass++;
        n_total++; if (orb !== 1'b0) $display("FAIL rst_ready_b: got %b required 0", orb); else n_pass++;
        @(posedge clk); #1 rst_n = 1;
        #1;
        n_total++; if (ora !== 1'b1) $display("FAIL rel_ready: got %b required 1", ora); else n_pass++;
        n_total++; if (orb !== 1'b1) $display("FAIL rel_ready_b: got %b required 1", orb); else n_pass++;
    endtask

    task automatic test_broadcast();
        @(posedge clk); #1 va = 1; da = 12'h3AB; ma = 3'b111; ra = 3'b000;
        @(negedge clk);
        n_total++; if (ora !== 1'b1) $display("FAIL bc_accept: got %b required 1", ora); else n_pass++;
        @(posedge clk); #1 va = 0; da = 12'hFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++; if (ova !== 3'b111) $display("FAIL bc_valid%0d: got %b required 111", i, ova); else n_pass++;
            n_total++; if (oda !== 12'h3AB) $display("FAIL bc_data%0d: got %h required 3ab", i, oda); else n_pass++;
            n_total++; if (ora !== 1'b0) $display("FAIL bc_ready%0d: got %b required 0", i, ora); else n_pass++;
        end
    endtask

    task automatic test_staggered();
        @(posedge clk); #1 ra = 3'b001;
        @(negedge clk);
        n_total++; if (ora !== 1'b0) $display("FAIL stg_ready0: got %b required 0", ora); else n_pass++;
        @(posedge clk); #1 ra = 3'b010;
        @(negedge clk);
        n_total++; if (ova !== 3'b110) $display("FAIL stg_valid1: got %b required 110", ova); else n_pass++;
        n_total++; if (ora !== 1'b0) $display("FAIL stg_ready1: got %b required 0", ora); else n_pass++;
        @(posedge clk); #1 ra = 3'b100;
        @(negedge clk);
        n_total++; if (ova !== 3'b100) $display("FAIL stg_valid2: got %b required 100", ova); else n_pass++;
        n_total++; if (ora !== 1'b1) $display("FAIL stg_ready2: got %b required 1", ora); else n_pass++;
        @(posedge clk); #1 ra = 3'b000;
        @(negedge clk);
        n_total++; if (ova !== 3'b000) $display("FAIL stg_valid3: got %b required 000", ova); else n_pass++;
    endtask

    task automatic test_masked();
        @(posedge clk); #1 va = 1; da = 12'h789; ma = 3'b101;
        @(posedge clk); #1 va = 0;
        @(negedge clk);
        n_total++; if (ova !== 3'b101) $display("FAIL msk_valid: got %b required 101", ova); else n_pass++;
        n_total++; if (oda !== 12'h7A9) $display("FAIL msk_data: got %h required 7a9", oda); else n_pass++;
        n_total++; if (ora !== 1'b0) $display("FAIL msk_ready: got %b required 0", ora); else n_pass++;
        @(posedge clk); #1 ra = 3'b111;
        @(negedge clk);
        n_total++; if (ora !== 1'b1) $display("FAIL msk_drain_ready: got %b required 1", ora); else n_pass++;
        @(posedge clk); #1 ra = 3'b000;
        @(negedge clk);
        n_total++; if (ova !== 3'b000) $display("FAIL msk_empty: got %b required 000", ova); else n_pass++;
    endtask

    task automatic test_back_to_back_a();
        ra = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 va = 1; da = 12'h111 * 12'(i + 1); ma = 3'b111;
            @(negedge clk);
            n_total++; if (ora !== 1'b1) $display("FAIL b2b_a_accept%0d: got %b required 1", i, ora); else n_pass++;
        end
        @(posedge clk); #1 va = 0;
        @(negedge clk);
        n_total++; if (oda !== 12'h333 || ova !== 3'b111) $display("FAIL b2b_a_last: got %h/%b required 333/111", oda, ova); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if (ova !== 3'b000) $display("FAIL b2b_a_empty: got %b required 000", ova); else n_pass++;
        ra = 3'b000;
    endtask

    task automatic test_back_to_back_b();
        int acc[3];
        int w;
        rb = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 vb = 1; db = 4'(i + 1); mb = 3'b111;
            w = 0;
            @(negedge clk);
            while (!orb && w < 4) begin
                @(negedge clk);
                w++;
            end
            n_total++; if (orb !== 1'b1) $display("FAIL b2b_b_timeout%0d: got %b required 1", i, orb); else n_pass++;
            acc[i] = cyc;
        end
        @(posedge clk); #1 vb = 0;
        n_total++; if (acc[1] - acc[0] != 2) $display("FAIL b2b_b_gap0: got %0d required 2", acc[1] - acc[0]); else n_pass++;
        n_total++; if (acc[2] - acc[1] != 2) $display("FAIL b2b_b_gap1: got %0d required 2", acc[2] - acc[1]); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rb = 3'b000;
        @(negedge clk);
        n_total++; if (ovb !== 3'b000) $display("FAIL b2b_b_empty: got %b required 000", ovb); else n_pass++;
    endtask

    task automatic test_split_no();
        @(posedge clk); #1 vb = 1; db = 4'hC; mb = 3'b011; rb = 3'b000;
        @(negedge clk);
        n_total++; if (orb !== 1'b1) $display("FAIL cp_accept: got %b required 1", orb); else n_pass++;
        @(posedge clk); #1 vb = 0;
        @(negedge clk);
        n_total++; if (ovb !== 3'b011) $display("FAIL cp_valid: got %b required 011", ovb); else n_pass++;
        n_total++; if (odb[7:0] !== 8'hCC) $display("FAIL cp_data: got %h required cc", odb[7:0]); else n_pass++;
        @(posedge clk); #1 rb = 3'b011;
        @(negedge clk);
        n_total++; if (orb !== 1'b0) $display("FAIL cp_drain_ready: got %b required 0", orb); else n_pass++;
        @(posedge clk); #1 rb = 3'b000;
        @(negedge clk);
        n_total++; if (ovb !== 3'b000 || orb !== 1'b1) $display("FAIL cp_after: got %b/%b required 000/1", ovb, orb); else n_pass++;
    endtask

    task automatic test_mask_zero();
        @(posedge clk); #1 va = 1; da = 12'h555; ma = 3'b000; ra = 3'b000;
        @(negedge clk);
        n_total++; if (ora !== 1'b1) $display("FAIL mz_accept: got %b required 1", ora); else n_pass++;
        @(posedge clk); #1 va = 0;
        @(negedge clk);
        n_total++; if (ova !== 3'b000 || ora !== 1'b1) $display("FAIL mz_after: got %b/%b required 000/1", ova, ora); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 va = 1; da = 12'h0DE; ma = 3'b011; ra = 3'b000;
        @(posedge clk); #1 va = 0;
        @(negedge clk);
        n_total++; if (ova !== 3'b011) $display("FAIL rm_valid: got %b required 011", ova); else n_pass++;
        @(posedge clk); #2 rst_n = 0;
        for (int k = 0; k < 3; k++) begin
            qa[k].delete();
            qb[k].delete();
        end
        #1;
        n_total++; if (ova !== 3'b000 || ora !== 1'b0) $display("FAIL rm_async: got %b/%b required 000/0", ova, ora); else n_pass++;
        @(posedge clk); #1 rst_n = 1; ra = 3'b111;
        repeat (3) @(negedge clk);
        n_total++; if (ova !== 3'b000 || ora !== 1'b1) $display("FAIL rm_after: got %b/%b required 000/1", ova, ora); else n_pass++;
        ra = 3'b000;
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_staggered();
        test_masked();
        test_back_to_back_a();
        test_back_to_back_b();
        test_split_no();
        test_mask_zero();
        test_reset_mid();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_total++; if (qa[k].size() != 0) $display("FAIL sb_a_left ch%0d: got %0d pending required 0", k, qa[k].size()); else n_pass++;
            n_total++; if (qb[k].size() != 0) $display("FAIL sb_b_left ch%0d: got %0d pending required 0", k, qb[k].size()); else n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
